// File: rtl/writeback_buffer_if.sv
//==============================================================================
// Module      : writeback_buffer_if
// Description : Result/store bus between execution lanes, writeback buffer
//               and register file.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface writeback_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int C_CNT_W = $clog2(DEPTH) + 1;

    logic [1:0]          resultValidIn;
    logic [1:0][4:0]     resultIndicesIn;
    logic [1:0][31:0]    resultValuesIn;
    logic                resultReadyOut;
    logic                registerReadyIn;
    logic [1:0][4:0]     storeIndicesOut;
    logic [1:0][31:0]    storeValuesOut;
    logic                storeLatchOut;
    logic [31:0]         pendingMaskOut;
    logic [C_CNT_W-1:0]  countOut;

    modport master (
        output resultValidIn, resultIndicesIn, resultValuesIn, registerReadyIn,
        input  resultReadyOut, storeIndicesOut, storeValuesOut, storeLatchOut,
               pendingMaskOut, countOut
    );

    modport slave (
        input  resultValidIn, resultIndicesIn, resultValuesIn, registerReadyIn,
        output resultReadyOut, storeIndicesOut, storeValuesOut, storeLatchOut,
               pendingMaskOut, countOut
    );
endinterface

`default_nettype wire

// File: rtl/writeback_buffer.sv
//==============================================================================
// Module      : writeback_buffer
// Description : Dual-lane in-order writeback FIFO with dual-port drain and
//               pending-write mask.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module writeback_buffer #(
    parameter int DEPTH = 8
) (
    input  wire logic         clockIn,
    input  wire logic         resetIn,
    writeback_buffer_if.slave bus
);
    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    logic [C_PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic [4:0]         mem_idx_q [DEPTH];
    logic [4:0]         mem_idx_d [DEPTH];
    logic [31:0]        mem_val_q [DEPTH];
    logic [31:0]        mem_val_d [DEPTH];
    logic [1:0][4:0]    store_idx_q, store_idx_d;
    logic [1:0][31:0]   store_val_q, store_val_d;
    logic               store_latch_q, store_latch_d;

    logic               w_ready;
    logic [1:0]         w_enq;
    logic               w_drain;
    logic               w_drain2;
    logic [C_PTR_W-1:0] w_head1;
    logic [C_CNT_W-1:0] w_n_enq;
    logic [C_CNT_W-1:0] w_n_drain;
    logic [31:0]        w_mask;
    logic [C_PTR_W-1:0] w_off [DEPTH];

    // Distance of each slot from head; wraps naturally at pointer width.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_off
        assign w_off[gi] = C_PTR_W'(gi) - head_q;
    end

    always_comb begin
        w_ready   = (count_q <= C_CNT_W'(DEPTH - 2)) && !resetIn;
        w_enq[0]  = w_ready && bus.resultValidIn[0] && (bus.resultIndicesIn[0] != 5'd0);
        w_enq[1]  = w_ready && bus.resultValidIn[1] && (bus.resultIndicesIn[1] != 5'd0);
        w_n_enq   = C_CNT_W'(w_enq[0]) + C_CNT_W'(w_enq[1]);
        w_head1   = head_q + C_PTR_W'(1);
        w_drain   = bus.registerReadyIn && (count_q != '0);
        // A second write to the same register waits so stores retire in order.
        w_drain2  = w_drain && (count_q >= C_CNT_W'(2))
                    && (mem_idx_q[w_head1] != mem_idx_q[head_q]);
        w_n_drain = C_CNT_W'(w_drain) + C_CNT_W'(w_drain2);

        mem_idx_d = mem_idx_q;
        mem_val_d = mem_val_q;
        if (w_enq[0]) begin
            mem_idx_d[tail_q] = bus.resultIndicesIn[0];
            mem_val_d[tail_q] = bus.resultValuesIn[0];
        end
        if (w_enq[1]) begin
            mem_idx_d[tail_q + C_PTR_W'(w_enq[0])] = bus.resultIndicesIn[1];
            mem_val_d[tail_q + C_PTR_W'(w_enq[0])] = bus.resultValuesIn[1];
        end

        tail_d        = tail_q + C_PTR_W'(w_n_enq);
        head_d        = head_q + C_PTR_W'(w_n_drain);
        count_d       = count_q + w_n_enq - w_n_drain;
        store_latch_d = w_drain;
        store_idx_d   = '0;
        store_val_d   = '0;
        if (w_drain) begin
            store_idx_d[0] = mem_idx_q[head_q];
            store_val_d[0] = mem_val_q[head_q];
        end
        if (w_drain2) begin
            store_idx_d[1] = mem_idx_q[w_head1];
            store_val_d[1] = mem_val_q[w_head1];
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, w_off[i]} < count_q) begin
                w_mask[mem_idx_q[i]] = 1'b1;
            end
        end
        if (store_latch_q) begin
            w_mask[store_idx_q[0]] = 1'b1;
            w_mask[store_idx_q[1]] = 1'b1;
        end
        w_mask[0] = 1'b0;
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            store_idx_q   <= '0;
            store_val_q   <= '0;
            store_latch_q <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            store_idx_q   <= store_idx_d;
            store_val_q   <= store_val_d;
            store_latch_q <= store_latch_d;
        end
    end

    // Entry storage is qualified by count, so it needs no reset.
    always_ff @(posedge clockIn) begin
        mem_idx_q <= mem_idx_d;
        mem_val_q <= mem_val_d;
    end

    assign bus.resultReadyOut  = w_ready;
    assign bus.storeIndicesOut = store_idx_q;
    assign bus.storeValuesOut  = store_val_q;
    assign bus.storeLatchOut   = store_latch_q;
    assign bus.pendingMaskOut  = w_mask;
    assign bus.countOut        = count_q;
endmodule

`default_nettype wire

// File: tb/tb_writeback_buffer.sv
//==============================================================================
// Module      : tb_writeback_buffer
// Description : Randomized scoreboard bench for writeback_buffer.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_writeback_buffer;
    localparam int DEPTH = 8;

    typedef struct { logic [4:0] idx; logic [31:0] val; } entry_t;
    typedef struct { logic [4:0] i0; logic [4:0] i1; logic [31:0] v0; logic [31:0] v1; } store_t;

    logic clk;
    logic rst;
    writeback_buffer_if #(.DEPTH(DEPTH)) bus ();

    writeback_buffer #(.DEPTH(DEPTH)) dut (
        .clockIn (clk),
        .resetIn (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    entry_t     fifo_m [$];
    store_t     exp_q  [$];
    logic       latch_m = 1'b0;
    logic [4:0] lidx_m [2] = '{5'd0, 5'd0};
    logic       acc_m = 1'b0;
    logic [31:0] rf_m [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (fifo_m[k]) m[fifo_m[k].idx] = 1'b1;
        if (latch_m) begin
            m[lidx_m[0]] = 1'b1;
            m[lidx_m[1]] = 1'b1;
        end
        m[0] = 1'b0;
        return m;
    endfunction

    // One clock: check registered state, drive inputs, then advance the model.
    task automatic cycle(input logic r, input logic v0, input logic [4:0] i0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] i1, input logic [31:0] d1, input logic rr);
        store_t rec;
        entry_t e;
        @(negedge clk);
        check("count", 32'(bus.countOut), fifo_m.size());
        check("count_bound", 32'(bus.countOut <= DEPTH), 1);
        check("mask", bus.pendingMaskOut, model_mask());
        check("latch", 32'(bus.storeLatchOut), 32'(latch_m));
        rst                     = r;
        bus.resultValidIn       = {v1, v0};
        bus.resultIndicesIn[0]  = i0;
        bus.resultIndicesIn[1]  = i1;
        bus.resultValuesIn[0]   = d0;
        bus.resultValuesIn[1]   = d1;
        bus.registerReadyIn     = rr;
        acc_m = !r && (DEPTH - fifo_m.size() >= 2);
        #1;
        check("ready", 32'(bus.resultReadyOut), 32'(acc_m));
        @(posedge clk);
        if (r) begin
            fifo_m.delete();
            latch_m = 1'b0;
            lidx_m  = '{5'd0, 5'd0};
        end else begin
            if (rr && fifo_m.size() >= 1) begin
                e      = fifo_m.pop_front();
                rec.i0 = e.idx;
                rec.v0 = e.val;
                rec.i1 = 5'd0;
                rec.v1 = 32'd0;
                if (fifo_m.size() >= 1 && fifo_m[0].idx != e.idx) begin
                    e      = fifo_m.pop_front();
                    rec.i1 = e.idx;
                    rec.v1 = e.val;
                end
                exp_q.push_back(rec);
                latch_m = 1'b1;
                lidx_m  = '{rec.i0, rec.i1};
            end else begin
                latch_m = 1'b0;
                lidx_m  = '{5'd0, 5'd0};
            end
            if (acc_m && v0 && i0 != 5'd0) fifo_m.push_back('{idx: i0, val: d0});
            if (acc_m && v1 && i1 != 5'd0) fifo_m.push_back('{idx: i1, val: d1});
        end
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rr);
    endtask

    // Store monitor: every latched store must be the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.storeLatchOut === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL store_unexpected: got idx %0d/%0d, expected no store at %0t",
                             bus.storeIndicesOut[0], bus.storeIndicesOut[1], $time);
                end else begin
                    store_t s;
                    s = exp_q.pop_front();
                    check("store_idx0", 32'(bus.storeIndicesOut[0]), 32'(s.i0));
                    check("store_val0", bus.storeValuesOut[0], s.v0);
                    check("store_idx1", 32'(bus.storeIndicesOut[1]), 32'(s.i1));
                    check("store_val1", bus.storeValuesOut[1], s.v1);
                end
                rf_m[bus.storeIndicesOut[0]] = bus.storeValuesOut[0];
                if (bus.storeIndicesOut[1] != 5'd0)
                    rf_m[bus.storeIndicesOut[1]] = bus.storeValuesOut[1];
            end
        end
    end

    initial begin
        logic        h_v0, h_v1;
        logic [4:0]  h_i0, h_i1;
        logic [31:0] h_d0, h_d1;
        logic        h_rr;
        foreach (rf_m[k]) rf_m[k] = 32'd0;
        rst                 = 1'b1;
        bus.resultValidIn   = '0;
        bus.resultIndicesIn = '0;
        bus.resultValuesIn  = '0;
        bus.registerReadyIn = 1'b0;
        repeat (2) @(posedge clk);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);

        // Single write
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1);
        #1 check("single_mask", bus.pendingMaskOut, 32'h20);
        idle(1'b1);
        #1;
        check("single_latch", 32'(bus.storeLatchOut), 1);
        check("single_idx0", 32'(bus.storeIndicesOut[0]), 5);
        check("single_idx1", 32'(bus.storeIndicesOut[1]), 0);
        check("single_val0", bus.storeValuesOut[0], 32'hDEADBEEF);
        idle(1'b1);
        #1;
        check("single_count_after", 32'(bus.countOut), 0);
        check("single_mask_after", bus.pendingMaskOut, 0);

        // x0 discard
        cycle(1'b0, 1'b1, 5'd0, 32'h11, 1'b1, 5'd3, 32'h33, 1'b0);
        #1;
        check("x0_count", 32'(bus.countOut), 1);
        check("x0_mask", bus.pendingMaskOut, 32'h8);
        repeat (2) idle(1'b1);

        // Same-index ordering
        cycle(1'b0, 1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 1'b0);
        idle(1'b1);
        #1;
        check("same_idx1", 32'(bus.storeIndicesOut[1]), 0);
        check("same_val0_first", bus.storeValuesOut[0], 1);
        idle(1'b1);
        #1 check("same_val0_second", bus.storeValuesOut[0], 2);
        idle(1'b0);
        check("same_rf7", rf_m[7], 2);

        // Backpressure
        for (int k = 0; k < 4; k++)
            cycle(1'b0, 1'b1, 5'(2*k+1), 32'(100+k), 1'b1, 5'(2*k+2), 32'(200+k), 1'b0);
        cycle(1'b0, 1'b1, 5'd9, 32'h999, 1'b1, 5'd10, 32'hAAA, 1'b0);
        #1;
        check("bp_full_count", 32'(bus.countOut), 8);
        check("bp_full_ready", 32'(bus.resultReadyOut), 0);
        cycle(1'b0, 1'b1, 5'd9, 32'h999, 1'b1, 5'd10, 32'hAAA, 1'b1);
        #1;
        check("bp_count_after_drain", 32'(bus.countOut), 6);
        check("bp_ready_after_drain", 32'(bus.resultReadyOut), 1);
        for (int k = 0; k < 4 && !acc_m; k++)
            cycle(1'b0, 1'b1, 5'd9, 32'h999, 1'b1, 5'd10, 32'hAAA, 1'b1);
        check("bp_held_accepted", 32'(acc_m), 1);
        for (int k = 0; k < 20 && (fifo_m.size() != 0 || latch_m); k++) idle(1'b1);

        // Randomized traffic with producer hold
        h_v0 = 1'b0; h_v1 = 1'b0; h_i0 = '0; h_i1 = '0; h_d0 = '0; h_d1 = '0;
        acc_m = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (acc_m || !(h_v0 || h_v1)) begin
                h_v0 = ($urandom_range(0, 3) != 0);
                h_v1 = ($urandom_range(0, 3) != 0);
                h_i0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
                h_i1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
                h_d0 = $urandom;
                h_d1 = $urandom;
            end
            h_rr = ($urandom_range(0, 2) != 0);
            cycle(1'b0, h_v0, h_i0, h_d0, h_v1, h_i1, h_d1, h_rr);
        end
        for (int k = 0; k < 20 && (fifo_m.size() != 0 || latch_m); k++) idle(1'b1);

        // Mid-operation reset
        cycle(1'b0, 1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12, 1'b0);
        cycle(1'b0, 1'b1, 5'd13, 32'h13, 1'b1, 5'd14, 32'h14, 1'b0);
        cycle(1'b0, 1'b1, 5'd15, 32'h15, 1'b0, 5'd0, 32'h0, 1'b0);
        #1 check("rst_pre_count", 32'(bus.countOut), 5);
        cycle(1'b1, 1'b1, 5'd16, 32'h16, 1'b1, 5'd17, 32'h17, 1'b1);
        #1;
        check("rst_count", 32'(bus.countOut), 0);
        check("rst_mask", bus.pendingMaskOut, 0);
        check("rst_latch", 32'(bus.storeLatchOut), 0);
        repeat (4) idle(1'b1);

        @(negedge clk);
        check("final_count", 32'(bus.countOut), 0);
        check("final_exp_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
